// File: rtl/sdram_pkg.sv
// Types and constants shared by the SDRAM transfer sequencer and the address calculator.
package sdram_pkg;

  localparam int ADDR_W = 26;

  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_REQ,
    RD_DRAIN,
    WR_REQ,
    DONE
  } xfer_state_t;

  // One extra bit so the counter can hold MAX_PEND itself.
  function automatic int pend_w(input int max_pend);
    return $clog2(max_pend) + 1;
  endfunction

endpackage

// File: rtl/sdram_pend_cnt.sv
// Outstanding-read counter: +1 per accepted read, -1 per returned beat, saturating at zero.
module sdram_pend_cnt
  import sdram_pkg::*;
#(
  parameter int MAX_PEND = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          inc,
  input  logic                          dec,
  output logic [pend_w(MAX_PEND)-1:0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = pend_w(MAX_PEND);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + PW'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - PW'(1);
    end
  end

  assign full  = (count >= PW'(MAX_PEND));
  assign empty = (count == '0);

endmodule

// File: rtl/sdram_xfer_ctrl.sv
// Single-burst SDRAM transfer sequencer driving the address calculator and Avalon-MM master.
// Define SDRAM_XFER_ERR_EN to add the sticky protocol-error output err.
module sdram_xfer_ctrl #(
  parameter int ADDR_W   = sdram_pkg::ADDR_W,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              calc_load,
  output logic              calc_enable,
  output logic              calc_mode,
  input  logic [ADDR_W-1:0] calc_address,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
`ifdef SDRAM_XFER_ERR_EN
  ,
  output logic              err
`endif
);

  import sdram_pkg::*;

  localparam int PW = pend_w(MAX_PEND);

  xfer_state_t      state, state_nxt;
  logic             mode_q;
  logic [CNT_W-1:0] remaining;
  logic             cmd_accept, rd_beat, last_beat;
  logic [PW-1:0]    pend_count;
  logic             pend_full, pend_empty, pend_zero_next;

  assign cmd_accept = (state == IDLE) && cmd_valid;
  assign rd_beat    = (state == RD_REQ) && calc_enable;
  assign last_beat  = calc_enable && (remaining == CNT_W'(1));
  // Pending count as it will be next cycle, so done lands right after the final return.
  assign pend_zero_next = !rd_beat &&
                          (pend_empty || ((pend_count == PW'(1)) && avm_readdatavalid));

  sdram_pend_cnt #(.MAX_PEND(MAX_PEND)) u_pend (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (rd_beat),
    .dec   (avm_readdatavalid),
    .count (pend_count),
    .full  (pend_full),
    .empty (pend_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cmd_valid) state_nxt = LOAD;
      LOAD: begin
        if (remaining == '0)          state_nxt = DONE;
        else if (mode_q == MODE_READ) state_nxt = RD_REQ;
        else                          state_nxt = WR_REQ;
      end
      RD_REQ:   if (last_beat) state_nxt = pend_zero_next ? DONE : RD_DRAIN;
      RD_DRAIN: if (pend_zero_next) state_nxt = DONE;
      WR_REQ:   if (last_beat) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    calc_load   = 1'b0;
    calc_enable = 1'b0;
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    wr_ready    = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:   cmd_ready = 1'b1;
      LOAD:   calc_load = 1'b1;
      RD_REQ: begin
        avm_read    = !pend_full;
        calc_enable = !pend_full && !avm_waitrequest;
      end
      WR_REQ: begin
        avm_write   = wr_valid;
        wr_ready    = wr_valid && !avm_waitrequest;
        calc_enable = wr_valid && !avm_waitrequest;
      end
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q    <= MODE_WRITE;
      remaining <= '0;
    end else if (cmd_accept) begin
      mode_q    <= cmd_mode;
      remaining <= cmd_count;
    end else if (calc_enable) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign calc_mode     = mode_q;
  assign avm_address   = calc_address;
  assign avm_writedata = wr_data;
  assign rd_valid      = avm_readdatavalid;
  assign rd_data       = avm_readdata;

`ifdef SDRAM_XFER_ERR_EN
  logic cmd_held_q;

  // One cycle of cmd_valid after acceptance is tolerated; a second one is flagged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err        <= 1'b0;
      cmd_held_q <= 1'b0;
    end else begin
      cmd_held_q <= cmd_valid && (state != IDLE);
      if (cmd_accept)
        err <= 1'b0;
      else if ((avm_readdatavalid && pend_empty) ||
               (cmd_valid && (state != IDLE) && cmd_held_q))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_xfer_ctrl.sv
// Directed bench for sdram_xfer_ctrl with a behavioural address-calculator model.
module tb_sdram_xfer_ctrl;
  import sdram_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [ADDR_W-1:0] BASE = 26'h0000100;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              cmd_valid, cmd_ready, cmd_mode;
  logic [CW-1:0]     cmd_count;
  logic              calc_load, calc_enable, calc_mode;
  logic [ADDR_W-1:0] calc_address, avm_address;
  logic              avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0]     avm_writedata, avm_readdata, wr_data, rd_data;
  logic              wr_valid, wr_ready, rd_valid, busy, done;
`ifdef SDRAM_XFER_ERR_EN
  logic              err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  sdram_xfer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DW), .CNT_W(CW), .MAX_PEND(4)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_mode          (cmd_mode),
    .cmd_count         (cmd_count),
    .calc_load         (calc_load),
    .calc_enable       (calc_enable),
    .calc_mode         (calc_mode),
    .calc_address      (calc_address),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .wr_data           (wr_data),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .busy              (busy),
    .done              (done)
`ifdef SDRAM_XFER_ERR_EN
    ,
    .err               (err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the calculator model registers load/enable seen before the edge.
  task automatic tick();
    logic ld, en;
    ld = calc_load;
    en = calc_enable;
    @(posedge clk);
    #1;
    cyc_n++;
    if (ld)      calc_address = BASE;
    else if (en) calc_address = calc_address + ADDR_W'(1);
  endtask

  int   n_en, n_acc, n_rdv, outst, max_out, last_rdv, done_cyc, n_done;
  logic acc, wt;
  logic [2:0] sr;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_count = '0;
    calc_address = '0; avm_waitrequest = 1'b0; avm_readdata = '0;
    avm_readdatavalid = 1'b0; wr_data = '0; wr_valid = 1'b0;

    // Reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_calc_load", calc_load, 0);
    chk("rst_calc_enable", calc_enable, 0);
    chk("rst_calc_mode", calc_mode, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_wr_ready", wr_ready, 0);
    n_rst = 1'b1;
    tick();

    // Write, count 4, no stalls
    cmd_valid = 1'b1; cmd_mode = MODE_WRITE; cmd_count = 16'd4;
    wr_valid = 1'b1; wr_data = 32'hA000_0000;
    #1;
    chk("wr4_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("wr4_load", calc_load, 1);
    chk("wr4_mode", calc_mode, 0);
    chk("wr4_no_write_in_load", avm_write, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA000_0000 + 32'(i);
      #1;
      chk("wr4_write", avm_write, 1);
      chk("wr4_enable", calc_enable, 1);
      chk("wr4_wr_ready", wr_ready, 1);
      chk("wr4_addr", avm_address, BASE + i);
      chk("wr4_wdata", avm_writedata, 32'hA000_0000 + i);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("wr4_done_T6", done, 1);
    chk("wr4_write_off", avm_write, 0);
    tick();
    chk("wr4_done_pulse", done, 0);
    chk("wr4_idle", cmd_ready, 1);

    // Read, count 8, waitrequest toggling, data 3 cycles after each accept
    cmd_valid = 1'b1; cmd_mode = MODE_READ; cmd_count = 16'd8;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("rd8_load", calc_load, 1);
    chk("rd8_mode", calc_mode, 1);
    n_en = 0; n_acc = 0; n_rdv = 0; outst = 0; max_out = 0;
    last_rdv = -100; done_cyc = -1; sr = '0; wt = 1'b1;
    for (int k = 0; k < 80 && done_cyc < 0; k++) begin
      tick();
      avm_waitrequest   = wt;
      wt                = ~wt;
      avm_readdatavalid = sr[2];
      avm_readdata      = 32'hD000_0000 + 32'(n_rdv);
      #1;
      if (done) done_cyc = cyc_n;
      if (rd_valid) begin
        chk("rd8_rdata", rd_data, 32'hD000_0000 + n_rdv);
        n_rdv++;
        outst--;
        last_rdv = cyc_n;
      end
      acc = avm_read && !avm_waitrequest;
      if (calc_enable) n_en++;
      if (acc) begin
        chk("rd8_addr", avm_address, BASE + n_acc);
        n_acc++;
        outst++;
      end
      if (outst > max_out) max_out = outst;
      sr = {sr[1:0], acc};
    end
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    chk("rd8_enables", n_en, 8);
    chk("rd8_accepts", n_acc, 8);
    chk("rd8_returns", n_rdv, 8);
    chk("rd8_pend_le_4", (max_out <= 4), 1);
    chk("rd8_done_cycle", done_cyc, last_rdv + 1);
    tick();

    // Read, count 6, returns withheld until the issue stalls at 4
    cmd_valid = 1'b1; cmd_mode = MODE_READ; cmd_count = 16'd6;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rd6_issue", avm_read, 1);
      chk("rd6_enable", calc_enable, 1);
      tick();
    end
    #1;
    chk("rd6_full_a", avm_read, 0);
    chk("rd6_full_no_enable", calc_enable, 0);
    tick();
    chk("rd6_full_b", avm_read, 0);
    tick();
    avm_readdatavalid = 1'b1;
    #1;
    chk("rd6_full_on_return", avm_read, 0);
    chk("rd6_rd_valid", rd_valid, 1);
    tick();
    #1;
    chk("rd6_resume", avm_read, 1);
    chk("rd6_resume_enable", calc_enable, 1);
    tick();
    avm_readdatavalid = 1'b0;
    #1;
    chk("rd6_after_same_cycle", avm_read, 1);
    tick();
    #1;
    chk("rd6_drain_no_read", avm_read, 0);
    chk("rd6_drain_busy", busy, 1);
    for (int j = 0; j < 4; j++) begin
      avm_readdatavalid = 1'b1;
      #1;
      chk("rd6_no_early_done", done, 0);
      tick();
    end
    avm_readdatavalid = 1'b0;
    #1;
    chk("rd6_done", done, 1);
    tick();
    chk("rd6_done_pulse", done, 0);

    // Zero-count write then read
    for (int m = 0; m < 2; m++) begin
      cmd_valid = 1'b1; cmd_mode = (m == 1); cmd_count = '0; wr_valid = 1'b1;
      #1;
      tick();
      cmd_valid = 1'b0;
      #1;
      chk("zero_load", calc_load, 1);
      chk("zero_no_write_T1", avm_write, 0);
      chk("zero_no_read_T1", avm_read, 0);
      tick();
      chk("zero_done_T2", done, 1);
      chk("zero_no_write_T2", avm_write, 0);
      chk("zero_no_read_T2", avm_read, 0);
      chk("zero_no_enable", calc_enable, 0);
      chk("zero_single_load", calc_load, 0);
      wr_valid = 1'b0;
      tick();
    end

    // Reset asserted mid-read with three reads outstanding
    cmd_valid = 1'b1; cmd_mode = MODE_READ; cmd_count = 16'd8;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("rst_mid_pre_read", avm_read, 1);
    n_rst = 1'b0;
    #1;
    chk("rst_mid_read", avm_read, 0);
    chk("rst_mid_enable", calc_enable, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_mode", calc_mode, 0);
    tick();
    n_rst = 1'b1;
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (done) n_done++;
      tick();
    end
    chk("rst_mid_no_done", n_done, 0);
    cmd_valid = 1'b1; cmd_mode = MODE_WRITE; cmd_count = 16'd1;
    wr_valid = 1'b1; wr_data = 32'h0BAD_F00D;
    #1;
    chk("rst_mid_new_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    tick();
    #1;
    chk("rst_mid_new_write", avm_write, 1);
    chk("rst_mid_new_addr", avm_address, BASE);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("rst_mid_new_done", done, 1);
    tick();

    // Stray read data in IDLE: forwarded, pending stays at zero
    avm_readdatavalid = 1'b1; avm_readdata = 32'h5A5A_5A5A;
    #1;
    chk("stray_rd_valid", rd_valid, 1);
    chk("stray_rd_data", rd_data, 32'h5A5A_5A5A);
    tick();
    avm_readdatavalid = 1'b0;
    #1;
`ifdef SDRAM_XFER_ERR_EN
    chk("stray_err_set", err, 1);
`endif
    cmd_valid = 1'b1; cmd_mode = MODE_READ; cmd_count = 16'd1;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
`ifdef SDRAM_XFER_ERR_EN
    chk("stray_err_cleared", err, 0);
`endif
    tick();
    #1;
    chk("stray_then_issue", avm_read, 1);
    tick();
    avm_readdatavalid = 1'b1;
    #1;
    chk("stray_then_no_early_done", done, 0);
    tick();
    avm_readdatavalid = 1'b0;
    #1;
    chk("stray_then_done", done, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_xfer_ctrl.md
# sdram_xfer_ctrl

Sequencer for one SDRAM burst transfer. It accepts a read or write command, drives `load`/`enable`/`mode` of the SDRAM address calculator, and issues Avalon-MM single-beat requests at the calculator's current address. For reads, it tracks outstanding requests until all data has returned. It sits directly upstream of the address calculator and between the frame buffers and the SDRAM controller's Avalon slave.

## Interface
Parameters:
- ADDR_W, 26, address width (matches calculator)
- DATA_W, 32, data word width
- CNT_W, 16, beat-count width
- MAX_PEND, 4, max outstanding reads (power of 2, ≥1)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  1  1 = read from SDRAM, 0 = write to SDRAM
- cmd_count  in  CNT_W  number of beats
- calc_load  out  1  load pulse to address calculator
- calc_enable  out  1  advance address calculator
- calc_mode  out  1  latched cmd_mode
- calc_address  in  ADDR_W  current address from calculator
- avm_address  out  ADDR_W  equals calc_address
- avm_read / avm_write  out  1  Avalon request strobes
- avm_writedata  out  DATA_W  equals wr_data
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W
- avm_readdatavalid  in  1
- wr_data  in  DATA_W, wr_valid  in  1, wr_ready  out  1  write-data source, valid/ready handshake
- rd_data  out  DATA_W, rd_valid  out  1  read-data sink, no backpressure
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse

## Operation
States are IDLE, LOAD, RD_REQ, RD_DRAIN, WR_REQ and DONE.

- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, latch mode and count into `remaining`, then go to LOAD.
- **LOAD**
  - calc_load = 1 for exactly one cycle.
  - Next state: DONE if remaining == 0, else RD_REQ if mode = 1, else WR_REQ.
- **RD_REQ**
  - avm_read = (pending < MAX_PEND).
  - A request is accepted when avm_read and !avm_waitrequest. On acceptance: calc_enable = 1, remaining −1, pending +1.
  - When the last request is accepted, go to RD_DRAIN.
- **RD_DRAIN**
  - No requests are issued.
  - When pending == 0, go to DONE. The same check applies on the cycle RD_REQ exits.
- **WR_REQ**
  - avm_write = wr_valid.
  - wr_ready = avm_write && !avm_waitrequest. On that beat: calc_enable = 1, remaining −1.
  - The source must hold wr_data/wr_valid stable until wr_ready.
  - When the last beat is accepted, go to DONE.
- **DONE**
  - done = 1 for one cycle, then go to IDLE.
- **Read data path** (any state)
  - rd_valid = avm_readdatavalid and rd_data = avm_readdata, combinational pass-through.
  - Each avm_readdatavalid decrements pending.
- **Pending arithmetic**
  - pending is $clog2(MAX_PEND)+1 bits wide.
  - Request acceptance and readdatavalid in the same cycle leave pending unchanged.
- **Boundaries**
  - The issue stalls at pending == MAX_PEND. This stall is the address "full" condition.
  - remaining reaching 0 terminates the request phase. The count never wraps.
  - Address wrap-around is owned by the calculator.

## Timing
- **Reset:** all outputs are 0 except cmd_ready = 1; state = IDLE; remaining = 0; pending = 0.
- **Reset mid-transfer:** the block returns to IDLE immediately, no done pulse is produced, and in-flight reads are abandoned.
- **Command accept at cycle T:**
  - calc_load at T+1.
  - First request asserted at T+2.
  - Address valid at T+2, because the calculator registers the load at the end of T+1.
- **Beat accepted at cycle N:** calc_enable is high in cycle N, and the next address appears on avm_address at N+1. Back-to-back beats are possible when waitrequest = 0.
- **done:**
  - Writes: done is asserted in the cycle after the last accepted write.
  - Reads: done is asserted in the cycle after the cycle in which pending reaches 0 with remaining == 0.
- **Zero-count command:** done at T+2.
- **Throughput:** the minimum command-to-command spacing is count + 3 cycles for writes.

## Configuration
- **SDRAM_XFER_ERR_EN defined:**
  - Adds output `err` (1 bit, sticky).
  - err is set when avm_readdatavalid arrives with pending == 0, or when cmd_valid is held high outside IDLE for more than one cycle. Neither case is legal.
  - err is cleared on the next command accept, and is 0 at reset.
- **Not defined:** the port is absent, and an unexpected readdatavalid is forwarded on rd_valid with pending saturating at 0.

## Structure
- **Package `sdram_pkg`:**
  - ADDR_W constant shared with the calculator.
  - State enum `xfer_state_t`.
  - Mode constants MODE_READ = 1, MODE_WRITE = 0.
- **Sub-module `sdram_pend_cnt`:** up/down counter with inc, dec, full and empty outputs, parameterized by MAX_PEND, holding the pending-read count.

## Test plan
- **Write, count = 4, waitrequest = 0, wr_valid held 1:** calc_load at T+1, four consecutive avm_write cycles with calc_enable, done at T+6.
- **Read, count = 8, waitrequest toggling 1/0, readdatavalid 3 cycles after each accept:** exactly 8 calc_enable pulses, pending never exceeds 4, 8 rd_valid pulses, done one cycle after the last one.
- **Read, count = 6, readdatavalid withheld:** avm_read drops after 4 accepts, the issue resumes on the first readdatavalid, and a same-cycle accept plus readdatavalid leaves pending at 4.
- **count = 0 in both modes:** no avm_read or avm_write, no calc_enable, one calc_load, done at T+2.
- **n_rst asserted mid-read with pending = 3:** outputs return to reset values the same cycle, no done pulse, and a new command is accepted after release.
- **With SDRAM_XFER_ERR_EN:** a stray readdatavalid in IDLE sets err = 1, and err is cleared on the next cmd accept.
